// File: rtl/ght_upd_sched_pkg.sv
// Shared types and constants for the global history table update scheduler.
package ght_upd_sched_pkg;

    localparam int GHT_NBANK  = 8;
    localparam int GHT_ADDR_W = 16;
    localparam int GHT_ROWS   = 32;
    localparam int GHT_DEPTH  = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ght_state_t;

    typedef struct packed {
        logic [GHT_ADDR_W-1:0] addr;
        logic                  val;
    } ght_upd_t;

    // Bank select: two middle index bits plus the low bit, so adjacent
    // rows of the sweep land in the same bank and odd entries interleave.
    function automatic logic [2:0] ght_bank_of(input logic [GHT_ADDR_W-1:0] addr);
        return {addr[7:6], addr[0]};
    endfunction

endpackage

// File: rtl/ght_upd_sched_if.sv
// Update-source and bank-side signal bundle for the GHT write scheduler.
interface ght_upd_sched_if
    import ght_upd_sched_pkg::*;
#(
    parameter int DEPTH = GHT_DEPTH
) ();

    // Handshake: updN_wen is a one-cycle request. It is accepted at the
    // rising edge only if upd_rdy is 1 in that cycle and init_req is 0.
    // A request seen with upd_rdy=0 is dropped (counted in drop_cnt) and is
    // never retried; the source does not hold it. upd1 is younger than upd0.
    logic                            init_req;
    logic                            upd0_wen;
    logic [GHT_ADDR_W-1:0]           upd0_addr;
    logic                            upd0_val;
    logic                            upd1_wen;
    logic [GHT_ADDR_W-1:0]           upd1_addr;
    logic                            upd1_val;
    logic                            upd_rdy;
    logic [GHT_NBANK-1:0]            bank_wen;
    logic [GHT_NBANK*GHT_ADDR_W-1:0] bank_addr;
    logic [GHT_NBANK-1:0]            bank_val;
    logic                            init_busy;
    logic [$clog2(DEPTH+1)-1:0]      q_count;
    logic [7:0]                      drop_cnt;
    ght_state_t                      state_dbg;

    modport master (
        output init_req, upd0_wen, upd0_addr, upd0_val,
               upd1_wen, upd1_addr, upd1_val,
        input  upd_rdy, bank_wen, bank_addr, bank_val,
               init_busy, q_count, drop_cnt, state_dbg
    );

    modport slave (
        input  init_req, upd0_wen, upd0_addr, upd0_val,
               upd1_wen, upd1_addr, upd1_val,
        output upd_rdy, bank_wen, bank_addr, bank_val,
               init_busy, q_count, drop_cnt, state_dbg
    );

endinterface

// File: rtl/ght_upd_queue.sv
// Age-ordered conflict queue: claims banks oldest-first, issues winners,
// compacts losers toward the head and appends blocked new requests.
module ght_upd_queue
    import ght_upd_sched_pkg::*;
#(
    parameter  int DEPTH = GHT_DEPTH,
    localparam int CW    = $clog2(DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in0_v,
    input  ght_upd_t              in0,
    input  logic                  in1_v,
    input  ght_upd_t              in1,
    output logic [GHT_NBANK-1:0]  iss_wen,
    output logic [GHT_ADDR_W-1:0] iss_addr [GHT_NBANK],
    output logic [GHT_NBANK-1:0]  iss_val,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         nxt_count
);

    ght_upd_t             mem     [DEPTH];
    ght_upd_t             nxt_mem [DEPTH];
    ght_upd_t             cand    [DEPTH+2];
    logic [DEPTH+1:0]     cand_v;
    logic [GHT_NBANK-1:0] seen;
    logic [2:0]           scan_bank;
    int                   wptr;

    // Candidate list in age order: queued entries, then upd0, then upd1.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i]   = mem[i];
            cand_v[i] = (i < int'(count));
        end
        cand[DEPTH]     = in0;
        cand_v[DEPTH]   = in0_v;
        cand[DEPTH+1]   = in1;
        cand_v[DEPTH+1] = in1_v;
    end

    // Claim scan: every scanned item marks its bank, so a blocked older
    // item still shields its bank from any younger item behind it.
    always_comb begin
        seen      = '0;
        scan_bank = '0;
        iss_wen   = '0;
        iss_val   = '0;
        nxt_mem   = mem;
        wptr      = 0;
        for (int k = 0; k < GHT_NBANK; k++) iss_addr[k] = '0;
        for (int i = 0; i < DEPTH+2; i++) begin
            if (cand_v[i]) begin
                scan_bank = ght_bank_of(cand[i].addr);
                if (!seen[scan_bank]) begin
                    iss_wen[scan_bank]  = 1'b1;
                    iss_addr[scan_bank] = cand[i].addr;
                    iss_val[scan_bank]  = cand[i].val;
                end else begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == wptr) nxt_mem[j] = cand[i];
                    end
                    wptr = wptr + 1;
                end
                seen[scan_bank] = 1'b1;
            end
        end
        nxt_count = CW'(wptr);
    end

    // Queue storage; clear discards all pending entries.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else begin
            count <= nxt_count;
            mem   <= nxt_mem;
        end
    end

    // Backpressure must keep the queue from ever overfilling.
    always_ff @(posedge clk) begin
        if (!rst) assert (int'(count) <= DEPTH);
    end

endmodule

// File: rtl/ght_upd_sched.sv
// GHT write scheduler: init sweep FSM, backpressure, drop counter and
// registered per-bank write outputs.
module ght_upd_sched
    import ght_upd_sched_pkg::*;
#(
    parameter int DEPTH = GHT_DEPTH,
    parameter int ROWS  = GHT_ROWS,
    parameter int NBANK = GHT_NBANK
) (
    input logic            clk,
    input logic            rst,
    ght_upd_sched_if.slave ifc
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(DEPTH+1);

    ght_state_t            state_q, state_d;
    logic [RW-1:0]         cnt_q, cnt_d;
    logic [NBANK-1:0]      wen_q, wen_d, val_q, val_d;
    logic [GHT_ADDR_W-1:0] addr_q [NBANK];
    logic [GHT_ADDR_W-1:0] addr_d [NBANK];
    logic [GHT_ADDR_W-1:0] row_addr;
    logic                  busy_q, busy_d, rdy_q, rdy_d;
    logic [7:0]            drop_q, drop_d;
    logic [8:0]            drop_sum;

    logic                  take0, take1;
    ght_upd_t              in0, in1;
    logic [GHT_NBANK-1:0]  q_iss_wen, q_iss_val;
    logic [GHT_ADDR_W-1:0] q_iss_addr [GHT_NBANK];
    logic [CW-1:0]         q_count, q_nxt_count;

    assign take0 = ifc.upd0_wen && rdy_q && !ifc.init_req;
    assign take1 = ifc.upd1_wen && rdy_q && !ifc.init_req;
    assign in0   = '{addr: ifc.upd0_addr, val: ifc.upd0_val};
    assign in1   = '{addr: ifc.upd1_addr, val: ifc.upd1_val};

    ght_upd_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (ifc.init_req),
        .in0_v     (take0),
        .in0       (in0),
        .in1_v     (take1),
        .in1       (in1),
        .iss_wen   (q_iss_wen),
        .iss_addr  (q_iss_addr),
        .iss_val   (q_iss_val),
        .count     (q_count),
        .nxt_count (q_nxt_count)
    );

    // Sweep row address: row index shifted up by one, upper bits zero.
    always_comb begin
        row_addr        = '0;
        row_addr[RW:1]  = cnt_q;
    end

    // Next state and next registered outputs; init_req overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = '0;
        val_d   = '0;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
        for (int k = 0; k < NBANK; k++) addr_d[k] = '0;
        if (ifc.init_req) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    wen_d  = '1;
                    busy_d = 1'b1;
                    for (int k = 0; k < NBANK; k++) addr_d[k] = row_addr;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == RW'(ROWS-1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    wen_d  = q_iss_wen;
                    val_d  = q_iss_val;
                    addr_d = q_iss_addr;
                    rdy_d  = (int'(q_nxt_count) <= DEPTH-2);
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Requests offered while not ready are counted, saturating at 255.
    always_comb begin
        drop_sum = {1'b0, drop_q};
        if (!ifc.init_req && !rdy_q)
            drop_sum = drop_sum + 9'(ifc.upd0_wen) + 9'(ifc.upd1_wen);
        drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            wen_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
            drop_q  <= '0;
            for (int k = 0; k < NBANK; k++) addr_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
        end
    end

    // Flatten per-bank addresses onto the bus, bank k at [16k+15:16k].
    always_comb begin
        for (int k = 0; k < NBANK; k++)
            ifc.bank_addr[k*GHT_ADDR_W +: GHT_ADDR_W] = addr_q[k];
    end

    assign ifc.bank_wen  = wen_q;
    assign ifc.bank_val  = val_q;
    assign ifc.init_busy = busy_q;
    assign ifc.upd_rdy   = rdy_q;
    assign ifc.q_count   = q_count;
    assign ifc.drop_cnt  = drop_q;
    assign ifc.state_dbg = state_q;

endmodule

// File: tb/tb_ght_upd_sched.sv
// Self-checking bench for ght_upd_sched: transaction-level model plus
// per-bank write-order scoreboard, directed cases and random traffic.
module tb_ght_upd_sched;

    localparam int DEPTH = 4;
    localparam int ROWS  = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ght_upd_sched_if #(.DEPTH(DEPTH)) ifc ();

    ght_upd_sched #(.DEPTH(DEPTH), .ROWS(ROWS), .NBANK(8)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc.slave)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        val;
    } ent_t;

    int tests = 0;
    int fails = 0;

    // Model state: pending requests in age order plus expected outputs.
    ent_t        m_q[$];
    logic [16:0] exp_q [8][$];
    bit          m_init;
    int          m_cnt;
    int          m_drop;
    logic [7:0]  e_wen, e_val;
    logic [15:0] e_addr [8];
    logic        e_busy, e_rdy;
    int          e_qc;

    function automatic int bank_of(input logic [15:0] a);
        return 2 * int'(a[7:6]) + (a[0] ? 1 : 0);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        for (int b = 0; b < 8; b++) exp_q[b].delete();
        m_init = 1'b1;
        m_cnt  = 0;
        e_busy = 1'b1;
        e_rdy  = 1'b0;
        e_qc   = 0;
    endtask

    task automatic model_step(input bit r, input bit ir,
                              input bit w0, input logic [15:0] a0, input bit v0,
                              input bit w1, input logic [15:0] a1, input bit v1);
        ent_t cand[$];
        ent_t keep[$];
        ent_t e;
        bit [7:0] claimed;
        int b;
        e_wen = '0;
        e_val = '0;
        for (int k = 0; k < 8; k++) e_addr[k] = '0;
        if (r) begin
            model_clear();
            m_drop = 0;
            return;
        end
        if (!ir && !e_rdy) begin
            m_drop = m_drop + int'(w0) + int'(w1);
            if (m_drop > 255) m_drop = 255;
        end
        if (ir) begin
            model_clear();
        end else if (m_init) begin
            e_wen = 8'hFF;
            for (int k = 0; k < 8; k++) e_addr[k] = 16'(m_cnt * 2);
            e_busy = 1'b1;
            e_rdy  = 1'b0;
            if (m_cnt == ROWS-1) m_init = 1'b0;
            m_cnt++;
        end else begin
            cand = m_q;
            if (w0 && e_rdy) begin
                e.addr = a0; e.val = v0;
                cand.push_back(e);
                exp_q[bank_of(a0)].push_back({v0, a0});
            end
            if (w1 && e_rdy) begin
                e.addr = a1; e.val = v1;
                cand.push_back(e);
                exp_q[bank_of(a1)].push_back({v1, a1});
            end
            claimed = '0;
            foreach (cand[i]) begin
                b = bank_of(cand[i].addr);
                if (!claimed[b]) begin
                    e_wen[b]  = 1'b1;
                    e_addr[b] = cand[i].addr;
                    e_val[b]  = cand[i].val;
                end else begin
                    keep.push_back(cand[i]);
                end
                claimed[b] = 1'b1;
            end
            m_q    = keep;
            e_busy = 1'b0;
            e_rdy  = (keep.size() <= DEPTH-2);
            e_qc   = keep.size();
        end
    endtask

    task automatic compare_all();
        logic [127:0] bus;
        logic [16:0]  got, want;
        for (int k = 0; k < 8; k++) bus[16*k +: 16] = e_addr[k];
        chk("bank_wen",  128'(ifc.bank_wen),  128'(e_wen));
        chk("bank_addr", ifc.bank_addr,       bus);
        chk("bank_val",  128'(ifc.bank_val),  128'(e_val));
        chk("init_busy", 128'(ifc.init_busy), 128'(e_busy));
        chk("upd_rdy",   128'(ifc.upd_rdy),   128'(e_rdy));
        chk("q_count",   128'(ifc.q_count),   128'(e_qc));
        chk("drop_cnt",  128'(ifc.drop_cnt),  128'(m_drop));
        if (!e_busy) begin
            for (int b = 0; b < 8; b++) begin
                if (ifc.bank_wen[b] === 1'b1) begin
                    got = {ifc.bank_val[b], ifc.bank_addr[16*b +: 16]};
                    if (exp_q[b].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL order_bank%0d: got write 0x%0h, want no write", b, got);
                    end else begin
                        want = exp_q[b].pop_front();
                        chk("order", 128'(got), 128'(want));
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit ir,
                        input bit w0, input logic [15:0] a0, input bit v0,
                        input bit w1, input logic [15:0] a1, input bit v1);
        rst           = r;
        ifc.init_req  = ir;
        ifc.upd0_wen  = w0;
        ifc.upd0_addr = a0;
        ifc.upd0_val  = v0;
        ifc.upd1_wen  = w1;
        ifc.upd1_addr = a1;
        ifc.upd1_val  = v1;
        model_step(r, ir, w0, a0, v0, w1, a1, v1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(0, 1) == 1) a[7:6] = 2'b00;
        return a;
    endfunction

    initial begin
        // Reset
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        chk("rst_wen",  128'(ifc.bank_wen),  128'h0);
        chk("rst_busy", 128'(ifc.init_busy), 128'h1);
        chk("rst_rdy",  128'(ifc.upd_rdy),   128'h0);
        chk("rst_drop", 128'(ifc.drop_cnt),  128'h0);

        // Post-reset sweep: 32 rows, then ready
        idle(1);
        chk("sweep_row0_wen",  128'(ifc.bank_wen), 128'hFF);
        chk("sweep_row0_addr", ifc.bank_addr,      128'h0);
        idle(30);
        idle(1);
        chk("sweep_row31_addr", 128'(ifc.bank_addr[127:112]), 128'h003E);
        chk("sweep_row31_busy", 128'(ifc.init_busy),           128'h1);
        idle(1);
        chk("run_busy", 128'(ifc.init_busy), 128'h0);
        chk("run_rdy",  128'(ifc.upd_rdy),   128'h1);
        chk("run_wen",  128'(ifc.bank_wen),  128'h0);

        // Two different banks in one cycle
        step(0, 0, 1, 16'h0000, 1, 1, 16'h0041, 0);
        chk("pair_wen",   128'(ifc.bank_wen),         128'h09);
        chk("pair_addr3", 128'(ifc.bank_addr[63:48]), 128'h0041);
        chk("pair_val",   128'(ifc.bank_val),         128'h01);
        chk("pair_qc",    128'(ifc.q_count),          128'h0);

        // Same bank: upd0 now, upd1 one cycle later
        step(0, 0, 1, 16'h1200, 0, 1, 16'h3400, 1);
        chk("same_addr0", 128'(ifc.bank_addr[15:0]), 128'h1200);
        chk("same_qc0",   128'(ifc.q_count),         128'h1);
        idle(1);
        chk("same_addr1", 128'(ifc.bank_addr[15:0]), 128'h3400);
        chk("same_qc1",   128'(ifc.q_count),         128'h0);

        // Ordering: queued A beats new B on bank0; C on bank2 goes alongside
        step(0, 0, 1, 16'h0000, 1, 1, 16'h0200, 1);
        step(0, 0, 1, 16'h0100, 0, 1, 16'h0040, 1);
        chk("ord_wen",   128'(ifc.bank_wen),         128'h05);
        chk("ord_a",     128'(ifc.bank_addr[15:0]),  128'h0200);
        chk("ord_c",     128'(ifc.bank_addr[47:32]), 128'h0040);
        idle(1);
        chk("ord_b",     128'(ifc.bank_addr[15:0]),  128'h0100);
        chk("ord_qc",    128'(ifc.q_count),          128'h0);

        // Backpressure on a single hot bank
        repeat (3) step(0, 0, 1, 16'h0010, 1, 1, 16'h0020, 0);
        chk("bp_qc3",  128'(ifc.q_count),  128'h3);
        chk("bp_rdy0", 128'(ifc.upd_rdy),  128'h0);
        step(0, 0, 1, 16'h0010, 1, 1, 16'h0020, 0);
        chk("bp_drop", 128'(ifc.drop_cnt), 128'h2);
        chk("bp_qc2",  128'(ifc.q_count),  128'h2);
        step(0, 0, 1, 16'h0010, 1, 1, 16'h0020, 0);
        chk("bp_qc3b", 128'(ifc.q_count),  128'h3);

        // init_req with a loaded queue: discard, resweep, no drop counted
        step(0, 1, 1, 16'h0010, 1, 1, 16'h0020, 0);
        chk("ir_qc",   128'(ifc.q_count),   128'h0);
        chk("ir_busy", 128'(ifc.init_busy), 128'h1);
        chk("ir_drop", 128'(ifc.drop_cnt),  128'h2);
        idle(33);
        chk("ir_done", 128'(ifc.init_busy), 128'h0);

        // Drop counter saturation during repeated sweeps
        repeat (4) begin
            step(0, 1, 0, 16'h0, 0, 0, 16'h0, 0);
            repeat (32) step(0, 0, 1, rand_addr(), 1, 1, rand_addr(), 0);
        end
        chk("drop_sat", 128'(ifc.drop_cnt), 128'd255);
        idle(2);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom),
                 ($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom));
        end
        idle(40);
        for (int b = 0; b < 8; b++) chk("drain", 128'(exp_q[b].size()), 128'h0);

        // Reset in the middle of a sweep
        step(0, 1, 0, 16'h0, 0, 0, 16'h0, 0);
        idle(10);
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        chk("mid_rst_busy", 128'(ifc.init_busy), 128'h1);
        chk("mid_rst_drop", 128'(ifc.drop_cnt),  128'h0);
        idle(33);
        chk("mid_rst_rdy",  128'(ifc.upd_rdy),   128'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ght_upd_sched.md
Name: ght_upd_sched

Overview:
Write scheduler for the 8-bank global history predictor table. Each cycle it accepts up to two retirement-side update requests and steers each to its bank, selected by {addr[7:6],addr[0]}. Same-bank conflicts are buffered in a small age-ordered queue, and per-bank write order is kept. It also sequences the post-reset and on-demand table init sweep, and applies backpressure to the update source.

Parameters:
DEPTH, 4, conflict queue entries (>=2)
ROWS, 32, init sweep rows per bank (power of two)
NBANK, 8, number of banks (fixed 8; bank index is 3 bits)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
init_req  in  1  pulse: discard queue, restart init sweep
upd0_wen  in  1  update 0 valid
upd0_addr  in  16  update 0 table address
upd0_val  in  1  update 0 data bit
upd1_wen  in  1  update 1 valid (younger than upd0)
upd1_addr  in  16  update 1 table address
upd1_val  in  1  update 1 data bit
upd_rdy  out  1  scheduler can take two requests this cycle
bank_wen  out  8  per-bank write enable
bank_addr  out  128  per-bank address, bank k at [16k+15:16k]
bank_val  out  8  per-bank write data
init_busy  out  1  init sweep in progress
q_count  out  clog2(DEPTH+1)  queued entries
drop_cnt  out  8  saturating count of requests dropped while upd_rdy=0

Behaviour:
- All outputs registered; write latency is 1 cycle from request (or queue issue) to bank_* outputs.
- Reset: state INIT, init counter=0, queue empty, drop_cnt=0, upd_rdy=0, bank_wen=0, bank_addr=0, bank_val=0, init_busy=1.
- FSM INIT: each cycle drive bank_wen=8'hFF, bank_val=0, every bank_addr={10'b0,cnt[4:0],1'b0}, and increment cnt.
  - On the cycle cnt==ROWS-1 is driven, go to RUN.
  - init_busy drops and upd_rdy rises on the first RUN output cycle.
  - The sweep therefore takes exactly ROWS cycles.
- FSM RUN, per-cycle scheduling with combinational claim vector seen[7:0]:
  - scan queue oldest to newest; an entry issues if seen[bank]==0; every scanned entry sets seen[bank], including blocked ones.
  - then apply the same rule to upd0, then upd1, if their wen is set and upd_rdy=1.
  - issued items drive bank_wen/addr/val for their bank next cycle; banks with no issue get wen=0, addr=0, val=0.
- Non-issued queue entries stay in age order and compact toward the head. Non-issued upd0, then upd1, are appended behind them.
- Guarantee: at most one write per bank per cycle; per-bank program order is preserved, so a younger request never bypasses an older one to the same bank.
- Backpressure: upd_rdy = RUN && (next q_count <= DEPTH-2), registered.
  - Requests presented with upd_rdy=0 are dropped.
  - drop_cnt increments by the number dropped (0..2) and saturates at 255.
- Overflow is impossible by construction. Assert that q_count never exceeds DEPTH.
- init_req, in any state, takes priority over updates that cycle:
  - queue cleared, cnt=0, go to INIT, upd_rdy=0 next cycle;
  - that cycle's requests are discarded and not counted as drops.
- Reset mid-sweep or mid-queue restarts from the reset state.
- Equal addresses in upd0 and upd1: same bank, so upd0 writes first and upd1 a cycle later. No merging.

Decomposition:
- Shared package: GHT_NBANK=8, GHT_ADDR_W=16, GHT_ROWS=32, and the bank-select function ght_bank_of(addr) returning {addr[7:6],addr[0]}. The same function is used by the bank wrapper.
- One natural sub-module: ght_upd_queue. It holds the age-ordered DEPTH-entry store with the claim scan, compaction and append, and outputs the issue vector and next count. ght_upd_sched keeps the FSM, init counter, backpressure, drop counter and output registers.

Test Plan:
- Reset, then idle -> 32 cycles of bank_wen=FF with addr 0x0000,0x0002,...,0x003E; init_busy=0 and upd_rdy=1 on cycle 33; no other writes.
- upd0=0x0000/val1, upd1=0x0041/val0 in the same cycle -> next cycle bank0 gets 0x0000/1 and bank3 gets 0x0041/0; q_count stays 0.
- upd0=0x1200, upd1=0x3400 (both bank0) -> cycle+1 bank0 writes 0x1200 with q_count=1; cycle+2 bank0 writes 0x3400 with q_count=0.
- Ordering: queue holds bank0 entry A, then new upd0 B for bank0 and upd1 C for bank2 -> A first while C issues the same cycle; B the next cycle; B never precedes A.
- Drive two bank0 requests every cycle -> upd_rdy falls once q_count>2 (DEPTH=4); later requests are dropped and drop_cnt steps by 2 per cycle; q_count never exceeds 4.
- init_req asserted while q_count=3 -> next cycle q_count=0 and init_busy=1; the queued entries are never written; a full 32-row sweep follows; drop_cnt is unchanged.
